// File: rtl/int_ctrl.sv
// rtl/int_ctrl.sv - 8051 interrupt controller owning TCON/IE/IP with vectored req/ack to the CPU core
module int_ctrl #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] wr_addr,
    input  logic [7:0] data_in,
    input  logic       wr,
    input  logic       wr_bit,
    input  logic       tf0,
    input  logic       tf1,
    input  logic       int0_n,
    input  logic       int1_n,
    input  logic       ser_int,
    input  logic       int_ack,
    input  logic       reti,
    output logic [7:0] tcon,
    output logic [7:0] ie,
    output logic [7:0] ip,
    output logic       int_req,
    output logic [7:0] int_vect
);

    localparam logic [7:0] SFR_TCON = 8'h88;
    localparam logic [7:0] SFR_IE   = 8'hA8;
    localparam logic [7:0] SFR_IP   = 8'hB8;
    localparam logic [7:0] IE_MASK  = 8'h9F;
    localparam logic [7:0] IP_MASK  = 8'h1F;

    typedef enum logic {IDLE, REQ} state_t;

    state_t state, state_next;

    logic [SYNC_STAGES-1:0] sync0, sync1;
    logic       int0_s, int1_s;
    logic       int0_prev, int1_prev;
    logic       tf0_prev, tf1_prev;
    logic       in_svc_hi, in_svc_lo;
    logic [2:0] src_q;
    logic       lvl_q;

    logic [7:0] tcon_next, ie_next, ip_next;
    logic       svc_hi_next, svc_lo_next;
    logic [4:0] pend, pend_hi, pend_lo;
    logic       win_valid, win_hi;
    logic [2:0] win_src;
    logic       ack_fire;

    assign int0_s = sync0[SYNC_STAGES-1];
    assign int1_s = sync1[SYNC_STAGES-1];

    // Bit order matches the fixed in-level priority: IE0, TF0, IE1, TF1, SER
    always_comb begin
        pend      = {ser_int & ie[4], tcon[7] & ie[3], tcon[3] & ie[2],
                     tcon[5] & ie[1], tcon[1] & ie[0]} & {5{ie[7]}};
        pend_hi   = pend & ip[4:0];
        pend_lo   = pend & ~ip[4:0];
        win_valid = 1'b0;
        win_hi    = 1'b0;
        win_src   = 3'd0;
        if (pend_hi != 5'd0 && !in_svc_hi) begin
            win_valid = 1'b1;
            win_hi    = 1'b1;
            for (int i = 4; i >= 0; i--)
                if (pend_hi[i]) win_src = 3'(i);
        end else if (pend_lo != 5'd0 && !in_svc_hi && !in_svc_lo) begin
            win_valid = 1'b1;
            for (int i = 4; i >= 0; i--)
                if (pend_lo[i]) win_src = 3'(i);
        end
    end

    always_comb begin
        state_next = state;
        ack_fire   = 1'b0;
        case (state)
            IDLE: if (win_valid) state_next = REQ;
            REQ: begin
                if (int_ack) begin
                    ack_fire   = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Update order gives precedence: software write, then ack clear, then hardware set
    always_comb begin
        tcon_next = tcon;
        ie_next   = ie;
        ip_next   = ip;
        if (wr && !wr_bit) begin
            case (wr_addr)
                SFR_TCON: tcon_next = data_in;
                SFR_IE:   ie_next   = data_in;
                SFR_IP:   ip_next   = data_in;
                default:  ;
            endcase
        end
        if (wr && wr_bit) begin
            case (wr_addr[7:3])
                SFR_TCON[7:3]: tcon_next[wr_addr[2:0]] = data_in[0];
                SFR_IE[7:3]:   ie_next[wr_addr[2:0]]   = data_in[0];
                SFR_IP[7:3]:   ip_next[wr_addr[2:0]]   = data_in[0];
                default:       ;
            endcase
        end
        ie_next = ie_next & IE_MASK;
        ip_next = ip_next & IP_MASK;
        if (ack_fire) begin
            case (src_q)
                3'd0:    if (tcon[0]) tcon_next[1] = 1'b0;
                3'd1:    tcon_next[5] = 1'b0;
                3'd2:    if (tcon[2]) tcon_next[3] = 1'b0;
                3'd3:    tcon_next[7] = 1'b0;
                default: ;
            endcase
        end
        if (tf0 && !tf0_prev) tcon_next[5] = 1'b1;
        if (tf1 && !tf1_prev) tcon_next[7] = 1'b1;
        if (tcon_next[0]) begin
            if (!int0_s && int0_prev) tcon_next[1] = 1'b1;
        end else begin
            tcon_next[1] = !int0_s;
        end
        if (tcon_next[2]) begin
            if (!int1_s && int1_prev) tcon_next[3] = 1'b1;
        end else begin
            tcon_next[3] = !int1_s;
        end
    end

    // RETI retires the innermost level before an ack in the same cycle claims one
    always_comb begin
        svc_hi_next = in_svc_hi;
        svc_lo_next = in_svc_lo;
        if (reti) begin
            if (in_svc_hi)      svc_hi_next = 1'b0;
            else if (in_svc_lo) svc_lo_next = 1'b0;
        end
        if (ack_fire) begin
            if (lvl_q) svc_hi_next = 1'b1;
            else       svc_lo_next = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            sync0     <= '1;
            sync1     <= '1;
            int0_prev <= 1'b1;
            int1_prev <= 1'b1;
            tf0_prev  <= 1'b0;
            tf1_prev  <= 1'b0;
            tcon      <= 8'h00;
            ie        <= 8'h00;
            ip        <= 8'h00;
            in_svc_hi <= 1'b0;
            in_svc_lo <= 1'b0;
            src_q     <= 3'd0;
            lvl_q     <= 1'b0;
            int_req   <= 1'b0;
            int_vect  <= 8'h00;
        end else begin
            state     <= state_next;
            sync0     <= {sync0[SYNC_STAGES-2:0], int0_n};
            sync1     <= {sync1[SYNC_STAGES-2:0], int1_n};
            int0_prev <= int0_s;
            int1_prev <= int1_s;
            tf0_prev  <= tf0;
            tf1_prev  <= tf1;
            tcon      <= tcon_next;
            ie        <= ie_next;
            ip        <= ip_next;
            in_svc_hi <= svc_hi_next;
            in_svc_lo <= svc_lo_next;
            int_req   <= (state_next == REQ);
            if (state == IDLE && win_valid) begin
                src_q    <= win_src;
                lvl_q    <= win_hi;
                int_vect <= 8'h03 + {2'b00, win_src, 3'b000};
            end
        end
    end

endmodule

// File: tb/tb_int_ctrl.sv
// tb/tb_int_ctrl.sv - directed self-checking bench for int_ctrl
module tb_int_ctrl;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] wr_addr = 8'h00;
    logic [7:0] data_in = 8'h00;
    logic       wr = 1'b0;
    logic       wr_bit = 1'b0;
    logic       tf0 = 1'b0;
    logic       tf1 = 1'b0;
    logic       int0_n = 1'b1;
    logic       int1_n = 1'b1;
    logic       ser_int = 1'b0;
    logic       int_ack = 1'b0;
    logic       reti = 1'b0;
    logic [7:0] tcon, ie, ip, int_vect;
    logic       int_req;

    int checks = 0;
    int failures = 0;

    int_ctrl #(.SYNC_STAGES(2)) dut (
        .clock(clock), .reset(reset), .wr_addr(wr_addr), .data_in(data_in),
        .wr(wr), .wr_bit(wr_bit), .tf0(tf0), .tf1(tf1), .int0_n(int0_n),
        .int1_n(int1_n), .ser_int(ser_int), .int_ack(int_ack), .reti(reti),
        .tcon(tcon), .ie(ie), .ip(ip), .int_req(int_req), .int_vect(int_vect)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    // Inputs change just after the falling edge; outputs are sampled there too
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            @(negedge clock);
        end
    endtask

    task automatic wr_byte(input logic [7:0] a, input logic [7:0] d);
        wr_addr = a; data_in = d; wr = 1'b1; wr_bit = 1'b0;
        step();
        wr = 1'b0;
    endtask

    task automatic wr_one(input logic [7:0] a, input logic b);
        wr_addr = a; data_in = {7'd0, b}; wr = 1'b1; wr_bit = 1'b1;
        step();
        wr = 1'b0; wr_bit = 1'b0;
    endtask

    task automatic ack();
        int_ack = 1'b1; step(); int_ack = 1'b0;
    endtask

    task automatic do_reti();
        reti = 1'b1; step(); reti = 1'b0;
    endtask

    task automatic do_reset();
        tf0 = 0; tf1 = 0; int0_n = 1; int1_n = 1; ser_int = 0;
        int_ack = 0; reti = 0; wr = 0; wr_bit = 0;
        reset = 1'b0; step(2); reset = 1'b1;
    endtask

    initial begin
        @(negedge clock);
        do_reset();
        check("rst_tcon", tcon, 8'h00);
        check("rst_ie", ie, 8'h00);
        check("rst_ip", ip, 8'h00);
        check("rst_req", {7'd0, int_req}, 8'h00);
        check("rst_vect", int_vect, 8'h00);

        // Timer 0 overflow, low level
        wr_byte(8'h88, 8'h10);
        wr_byte(8'hA8, 8'h82);
        tf0 = 1'b1; step(); tf0 = 1'b0;
        check("t1_tcon", tcon, 8'h30);
        check("t1_req_early", {7'd0, int_req}, 8'h00);
        step();
        check("t1_req", {7'd0, int_req}, 8'h01);
        check("t1_vect", int_vect, 8'h0B);
        ack();
        check("t1_ack_tcon", tcon, 8'h10);
        check("t1_ack_req", {7'd0, int_req}, 8'h00);
        wr_byte(8'hA8, 8'hFF);
        check("ie_mask", ie, 8'h9F);
        wr_byte(8'hB8, 8'hFF);
        check("ip_mask", ip, 8'h1F);

        // External 0 edge mode: synchroniser latency and no re-set on held pin
        do_reset();
        wr_byte(8'h88, 8'h01);
        wr_byte(8'hA8, 8'h81);
        int0_n = 1'b0;
        step(2);
        check("t2_ie0_early", tcon, 8'h01);
        step();
        check("t2_ie0_set", tcon, 8'h03);
        step();
        check("t2_req", {7'd0, int_req}, 8'h01);
        check("t2_vect", int_vect, 8'h03);
        ack();
        check("t2_ack_tcon", tcon, 8'h01);
        step(3);
        check("t2_held_tcon", tcon, 8'h01);
        check("t2_held_req", {7'd0, int_req}, 8'h00);

        // Level mode follows the pin
        do_reset();
        int1_n = 1'b0;
        step(3);
        check("lvl_ie1_set", tcon, 8'h08);
        int1_n = 1'b1;
        step(3);
        check("lvl_ie1_clr", tcon, 8'h00);

        // High-level TF1 beats low-level IE0; IE0 follows after reti
        do_reset();
        wr_byte(8'h88, 8'h83);
        wr_byte(8'hB8, 8'h08);
        wr_byte(8'hA8, 8'h89);
        step();
        check("t3_req", {7'd0, int_req}, 8'h01);
        check("t3_vect_hi", int_vect, 8'h1B);
        ack();
        check("t3_ack_tcon", tcon, 8'h03);
        step();
        check("t3_blocked", {7'd0, int_req}, 8'h00);
        do_reti();
        step();
        check("t3_req_lo", {7'd0, int_req}, 8'h01);
        check("t3_vect_lo", int_vect, 8'h03);

        // Nesting: low TF0 in service, high serial preempts, low blocked until two retis
        do_reset();
        wr_byte(8'h88, 8'h20);
        wr_byte(8'hB8, 8'h10);
        wr_byte(8'hA8, 8'h92);
        step();
        check("t4_vect_tf0", int_vect, 8'h0B);
        ack();
        ser_int = 1'b1;
        step();
        check("t4_req_ser", {7'd0, int_req}, 8'h01);
        check("t4_vect_ser", int_vect, 8'h23);
        ack();
        ser_int = 1'b0;
        wr_one(8'h8D, 1'b1);
        step(2);
        check("t4_blk_a", {7'd0, int_req}, 8'h00);
        do_reti();
        step();
        check("t4_blk_b", {7'd0, int_req}, 8'h00);
        do_reti();
        step();
        check("t4_req_after", {7'd0, int_req}, 8'h01);
        check("t4_vect_after", int_vect, 8'h0B);

        // Hardware set beats same-cycle software clear
        do_reset();
        wr_addr = 8'h8D; data_in = 8'h00; wr = 1'b1; wr_bit = 1'b1; tf0 = 1'b1;
        step();
        wr = 1'b0; wr_bit = 1'b0; tf0 = 1'b0;
        check("t5_tcon", tcon, 8'h20);

        // Request frozen while disabled, dropped by reset
        do_reset();
        wr_byte(8'h88, 8'h20);
        wr_byte(8'hA8, 8'h82);
        step();
        check("t6_req", {7'd0, int_req}, 8'h01);
        wr_byte(8'hA8, 8'h00);
        step();
        check("t6_held_req", {7'd0, int_req}, 8'h01);
        check("t6_held_vect", int_vect, 8'h0B);
        reset = 1'b0; step(); reset = 1'b1;
        check("t6_rst_req", {7'd0, int_req}, 8'h00);
        check("t6_rst_tcon", tcon, 8'h00);
        check("t6_rst_ie", ie, 8'h00);
        check("t6_rst_ip", ip, 8'h00);
        check("t6_rst_vect", int_vect, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
